mole_round_ctrl: RTL and testbench
==================================

Name: mole_round_ctrl

Overview:
Game-round controller for the whack-a-mole datapath. Sits directly downstream of the pseudo RNG. It pulses the RNG's generate enable, captures the one-hot mole selection, and lights that mole for a fixed window. It also edge-detects the five player buttons, scores hits, counts misses, and ends the game after a miss limit.

Parameters:
UP_CYCLES, 50000000, cycles a mole stays lit (1 s at 50 MHz)
GAP_CYCLES, 25000000, dark cycles between moles
RNG_WAIT, 2, cycles between gen_en pulse and sampling rng_data
MAX_MISSES, 3, misses that end the game (1..15)
SCORE_W, 8, score width

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high; clock clock
start  input  1  start/restart request, level sampled each cycle
buttons  input  5  player buttons, active-high, already synchronised/debounced
rng_data  input  5  one-hot mole index from RNG
gen_en  output  1  one-cycle request pulse to RNG
mole  output  5  currently lit mole, one-hot or zero
score  output  SCORE_W  hit count, saturating
misses  output  4  miss count
busy  output  1  high in REQ/WAIT_RNG/UP/GAP
game_over  output  1  high in OVER

Behaviour:
- Reset (any state, mid-round included) clears state to IDLE, mole=0, score=0, misses=0, gen_en=0, timer=0, btn_prev=5'b11111. Buttons held through reset never register as presses.
- All outputs are registered. busy and game_over decode state.
- Press edge: press = buttons & ~btn_prev. btn_prev <= buttons every cycle in all non-reset states.
- IDLE: start=1 -> REQ. Score/misses already zero.
- REQ: gen_en=1 for exactly this one cycle -> WAIT_RNG, timer <= RNG_WAIT-1.
- WAIT_RNG: timer decrements. When timer==0:
  - Sample rng_data into mole.
  - If rng_data is not exactly one-hot (zero or multi-bit), mole <= 5'b00001.
  - timer <= UP_CYCLES-1 -> UP.
- UP: mole is lit for exactly UP_CYCLES cycles unless hit. Per cycle:
  - Hit: (press & mole)!=0. Score += 1, saturating at all-ones. mole <= 0, timer <= GAP_CYCLES-1 -> GAP.
  - Wrong press: press!=0 with no hit. misses += 1, stays in UP, timer keeps running. Multiple wrong bits in one cycle count once.
  - Expiry: timer==0 and no hit. misses += 1, mole <= 0 -> GAP.
  - Hit with wrong bits in the same cycle: hit only, no miss.
  - Hit on the same cycle as expiry: hit wins.
  - Wrong press on the same cycle as expiry: one miss only.
- Miss limit: if a miss makes misses==MAX_MISSES, next state is OVER instead of GAP/UP, and mole <= 0. misses saturates at MAX_MISSES.
- GAP: mole=0, timer decrements. At timer==0 -> REQ. Presses are ignored.
- OVER: mole=0, game_over=1, score/misses held for display. start=1 clears score and misses -> REQ.
- start is ignored in REQ, WAIT_RNG, UP and GAP.
- gen_en never asserts outside REQ. The RNG latches on the gen_en rising edge, so a single-cycle pulse is required.
- Timer width is $clog2 of the max of UP_CYCLES, GAP_CYCLES and RNG_WAIT, plus 1.

Test Plan:
Use params UP_CYCLES=8, GAP_CYCLES=4, RNG_WAIT=2, MAX_MISSES=3.
1. Reset, start pulse; model rng_data=5'b00100 -> gen_en high exactly 1 cycle, 2 cycles after REQ mole=00100, busy=1, score=0.
2. Mole 00100 lit, buttons=00100 on UP cycle 3 -> next cycle score=1, mole=0. After 4 GAP cycles gen_en pulses again.
3. Never press -> mole lit exactly 8 cycles, misses=1. Repeat twice -> misses=3, game_over=1, mole=0, gen_en stays 0. start -> score=0, misses=0, gen_en pulses.
4. Mole 01000, buttons=00001 then released -> misses=1, mole still 01000. Then buttons=01001 (rising on both) -> score+1, misses stays 1.
5. Buttons=11111 held across reset and start -> no presses counted. rng_data=0 -> mole=00001. rng_data=00110 -> mole=00001.
6. Assert reset in the middle of UP with score=2 -> next cycle IDLE, mole=0, score=0, misses=0, busy=0. Force score=255 and hit -> score stays 255.

Source files
------------

// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round controller: RNG handshake, mole window, scoring
module mole_round_ctrl #(
  parameter int unsigned UP_CYCLES  = 50000000,
  parameter int unsigned GAP_CYCLES = 25000000,
  parameter int unsigned RNG_WAIT   = 2,
  parameter int unsigned MAX_MISSES = 3,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         buttons,
  input  logic [4:0]         rng_data,
  output logic               gen_en,
  output logic [4:0]         mole,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic               busy,
  output logic               game_over
);

  localparam int unsigned MAX_UG  = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_T   = (MAX_UG > RNG_WAIT) ? MAX_UG : RNG_WAIT;
  localparam int unsigned TIMER_W = $clog2(MAX_T) + 1;

  localparam logic [TIMER_W-1:0] UP_LOAD   = TIMER_W'(UP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'((RNG_WAIT > 0) ? RNG_WAIT - 1 : 0);
  localparam logic [3:0]         MAX_M     = 4'(MAX_MISSES);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RNG,
    UP,
    GAP,
    OVER
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [4:0]           mole_q, mole_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [3:0]           misses_q, misses_d;
  logic [4:0]           btn_prev_q;
  logic                 gen_en_q, busy_q, game_over_q;

  logic [4:0]           press;
  logic                 hit;
  logic                 wrong;
  logic                 expire;
  logic [3:0]           misses_inc;
  logic [SCORE_W-1:0]   score_inc;

  assign press      = buttons & ~btn_prev_q;
  assign hit        = |(press & mole_q);
  assign wrong      = (|press) && !hit;
  assign expire     = (timer_q == '0);
  assign misses_inc = (misses_q < MAX_M) ? misses_q + 4'd1 : misses_q;
  assign score_inc  = (&score_q) ? score_q : score_q + SCORE_W'(1);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    mole_d   = mole_q;
    score_d  = score_q;
    misses_d = misses_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = REQ;
      end
      REQ: begin
        timer_d = WAIT_LOAD;
        state_d = WAIT_RNG;
      end
      WAIT_RNG: begin
        if (expire) begin
          // A corrupt RNG word still has to light exactly one mole
          mole_d  = $onehot(rng_data) ? rng_data : 5'b00001;
          timer_d = UP_LOAD;
          state_d = UP;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      UP: begin
        if (hit) begin
          score_d = score_inc;
          mole_d  = '0;
          timer_d = GAP_LOAD;
          state_d = GAP;
        end else if (wrong || expire) begin
          // Wrong press and expiry in the same cycle collapse to a single miss
          misses_d = misses_inc;
          if (misses_inc == MAX_M) begin
            mole_d  = '0;
            state_d = OVER;
          end else if (expire) begin
            mole_d  = '0;
            timer_d = GAP_LOAD;
            state_d = GAP;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      GAP: begin
        if (expire) state_d = REQ;
        else        timer_d = timer_q - TIMER_W'(1);
      end
      OVER: begin
        if (start) begin
          score_d  = '0;
          misses_d = '0;
          state_d  = REQ;
        end
      end
      default: begin
        mole_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      mole_q      <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      btn_prev_q  <= 5'b11111;
      gen_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mole_q      <= mole_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      btn_prev_q  <= buttons;
      gen_en_q    <= (state_d == REQ);
      busy_q      <= (state_d == REQ) || (state_d == WAIT_RNG) ||
                     (state_d == UP)  || (state_d == GAP);
      game_over_q <= (state_d == OVER);
    end
  end

  assign gen_en    = gen_en_q;
  assign mole      = mole_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb/tb_mole_round_ctrl.sv - directed self-checking bench for mole_round_ctrl
module tb_mole_round_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic [4:0] buttons;
  logic [4:0] rng_data;
  logic       gen_en;
  logic [4:0] mole;
  logic [7:0] score;
  logic [3:0] misses;
  logic       busy;
  logic       game_over;

  int checks = 0;
  int failures = 0;
  int n;
  int gen_seen;

  mole_round_ctrl #(
    .UP_CYCLES (8),
    .GAP_CYCLES(4),
    .RNG_WAIT  (2),
    .MAX_MISSES(3),
    .SCORE_W   (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .buttons  (buttons),
    .rng_data (rng_data),
    .gen_en   (gen_en),
    .mole     (mole),
    .score    (score),
    .misses   (misses),
    .busy     (busy),
    .game_over(game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic stepn(input int k);
    for (int i = 0; i < k; i++) @(negedge clock);
  endtask

  // Steps until gen_en is seen high; returns cycles taken (20 means it never came)
  task automatic wait_gen(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (gen_en !== 1'b1 && cnt < 20);
  endtask

  // Called with the mole already lit; returns total cycles it stayed lit
  task automatic count_lit(output int cnt);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mole != 5'b0) cnt++;
      else break;
    end
  endtask

  task automatic do_hit(input logic [4:0] m);
    int c;
    stepn(3);
    buttons = m;
    step();
    buttons = 5'b0;
    wait_gen(c);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    buttons  = 5'b0;
    rng_data = 5'b00100;
    stepn(2);
    chk("rst_mole", mole, 5'b0);
    chk("rst_score", score, 8'd0);
    chk("rst_misses", misses, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_over", game_over, 1'b0);
    chk("rst_gen", gen_en, 1'b0);
    reset = 1'b0;
    step();

    // 1: start -> single gen_en pulse, mole after the RNG wait
    start = 1'b1;
    step();
    chk("t1_gen_hi", gen_en, 1'b1);
    chk("t1_busy", busy, 1'b1);
    start = 1'b0;
    step();
    chk("t1_gen_lo", gen_en, 1'b0);
    chk("t1_mole_wait", mole, 5'b0);
    stepn(2);
    chk("t1_mole", mole, 5'b00100);
    chk("t1_score", score, 8'd0);

    // 2: hit on UP cycle 3, then 4 gap cycles before next request
    stepn(2);
    chk("t2_still_lit", mole, 5'b00100);
    buttons = 5'b00100;
    step();
    buttons = 5'b0;
    chk("t2_score", score, 8'd1);
    chk("t2_mole_off", mole, 5'b0);
    chk("t2_misses", misses, 4'd0);
    wait_gen(n);
    chk("t2_gap_len", n, 4);

    // 3: three unanswered moles end the game
    for (int r = 1; r <= 3; r++) begin
      stepn(3);
      count_lit(n);
      chk("t3_lit_len", n, 8);
      chk("t3_misses", misses, r);
      if (r < 3) begin
        wait_gen(n);
        chk("t3_gap_len", n, 4);
      end
    end
    chk("t3_over", game_over, 1'b1);
    chk("t3_busy", busy, 1'b0);
    chk("t3_score_held", score, 8'd1);
    gen_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (gen_en !== 1'b0 || mole !== 5'b0) gen_seen++;
    end
    chk("t3_over_quiet", gen_seen, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_restart_gen", gen_en, 1'b1);
    chk("t3_restart_score", score, 8'd0);
    chk("t3_restart_misses", misses, 4'd0);
    chk("t3_restart_over", game_over, 1'b0);

    // 4: wrong press keeps the mole, then combined hit+wrong scores only
    rng_data = 5'b01000;
    stepn(3);
    chk("t4_mole", mole, 5'b01000);
    buttons = 5'b00001;
    step();
    chk("t4_wrong_miss", misses, 4'd1);
    chk("t4_wrong_mole", mole, 5'b01000);
    buttons = 5'b0;
    step();
    chk("t4_release", misses, 4'd1);
    buttons = 5'b01001;
    step();
    buttons = 5'b0;
    chk("t4_hit_score", score, 8'd1);
    chk("t4_hit_misses", misses, 4'd1);
    chk("t4_hit_mole", mole, 5'b0);
    wait_gen(n);
    chk("t4_gap_len", n, 4);

    // 5: buttons held through reset never count; bad RNG words fall back to mole 0
    buttons = 5'b11111;
    reset   = 1'b1;
    stepn(2);
    reset = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    rng_data = 5'b00000;
    stepn(3);
    chk("t5_zero_rng", mole, 5'b00001);
    step();
    chk("t5_held_score", score, 8'd0);
    chk("t5_held_misses", misses, 4'd0);
    buttons = 5'b0;
    step();
    chk("t5_release_misses", misses, 4'd0);
    buttons = 5'b00001;
    step();
    buttons = 5'b0;
    chk("t5_hit", score, 8'd1);
    wait_gen(n);
    rng_data = 5'b00110;
    stepn(3);
    chk("t5_multi_rng", mole, 5'b00001);

    // 6: reset mid-UP, then score saturation
    buttons = 5'b00001;
    step();
    buttons = 5'b0;
    wait_gen(n);
    stepn(3);
    chk("t6_score2", score, 8'd2);
    chk("t6_lit", mole, 5'b00001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_mole", mole, 5'b0);
    chk("t6_rst_score", score, 8'd0);
    chk("t6_rst_misses", misses, 4'd0);
    chk("t6_rst_busy", busy, 1'b0);
    rng_data = 5'b00010;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 255; i++) do_hit(5'b00010);
    chk("t6_score255", score, 8'd255);
    do_hit(5'b00010);
    chk("t6_score_sat", score, 8'd255);
    chk("t6_sat_misses", misses, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
